dbus_pair_server: RTL and testbench
===================================

// Module: dbus_pair_server
// PURPOSE
//  Responder for the dual-issue memory stage: accepts two dbus_req_t (slot 1 = older, slot 0 = younger).
//  Serializes them onto one downstream dbus (cache/uncached path), one transaction outstanding.
//  Returns per-slot load data, req_finish[1:0] (drops the slot's valid) and a stall until both are served.
//  Sits between the memory stage and the dcache/uncached bridge.
// PARAMETERS
//  FAST_DONE  1  1: data_ok in the addr_ok cycle completes with no WAIT cycle; 0: always pass through WAIT
//  ZERO_WAIT  1  1: slot 0 issued in the cycle after slot 1 completes; 0: one IDLE bubble in between
// PORTS
//  clk           in   1             clock
//  reset         in   1             asynchronous, active-high
//  dreq          in   dbus_req_t x2 requests from memory stage; [1] older, [0] younger
//  advance       in   1             pipeline moves M->W this cycle; clears finish bookkeeping
//  flush         in   1             exception/ERET: cancel slots not yet issued
//  dreq_out      out  dbus_req_t    single downstream request
//  dresp_in      in   dbus_resp_t   downstream addr_ok / data_ok / data
//  req_finish    out  2             slot i served this M-stage occupancy (sticky until advance)
//  rdata         out  word_t x2     captured load data per slot (raw word, unshifted)
//  stall_m       out  1             hold the pipeline: a valid, unfinished slot remains
// BEHAVIOUR
//  Reset: state=IDLE, dreq_out='0, req_finish=2'b00, rdata='{0,0}, stall_m=0; async, takes effect mid-transfer.
//  FSM states: IDLE, REQ1, WAIT1, REQ0, WAIT0.
//  IDLE: if dreq[1].valid & ~req_finish[1] -> REQ1; else if dreq[0].valid & ~req_finish[0] -> REQ0.
//  REQn: dreq_out = dreq[n] (valid,addr,size,strobe,data), held stable until dresp_in.addr_ok.
//   addr_ok & data_ok same cycle & FAST_DONE -> finish n; else addr_ok -> WAITn.
//  WAITn: dreq_out.valid=0; on data_ok -> finish n.
//  finish n: req_finish[n]<=1; rdata[n]<=dresp_in.data when strobe==0 (load), else rdata[n] unchanged.
//   After slot 1: go REQ0 (ZERO_WAIT=1) or IDLE if slot 0 pending; else IDLE.
//  Ordering: slot 1 always issued before slot 0 in the same occupancy; never reordered.
//  stall_m = OR over i of (dreq[i].valid & ~req_finish[i]); combinational; 0 in IDLE with nothing pending.
//  advance: req_finish<=2'b00 next edge; only legal with stall_m=0; an advance while state!=IDLE is an
//   assertion failure.
//  flush in IDLE/REQn before addr_ok: drop to IDLE, dreq_out.valid=0 next cycle, no finish set.
//  flush in WAITn: must drain; remain in WAITn until data_ok, then IDLE; data discarded, no finish set.
//  flush while in REQn in the addr_ok cycle: transaction accepted -> WAITn drain (or IDLE if data_ok too).
//  Memory stage drops dreq[i].valid once req_finish[i]=1; finished slots are never reissued.
//  Store slot (strobe!=0): same sequence; data_ok still required before finish.
//  Single slot valid: only that slot issued, other finish bit stays 0.
//  Downstream contract: addr_ok only while dreq_out.valid; data_ok never before addr_ok.
// TESTING
//  1) dreq[1]=load 0x8000_0010, dreq[0]=load 0x8000_0014; addr_ok+data_ok same cycle, data A/B ->
//     rdata[1]=A, rdata[0]=B, req_finish=2'b11 after 2 cycles, stall_m low in cycle 3.
//  2) Only dreq[0]=store 0xA000_0000 strobe 4'hF; addr_ok at cycle 2, data_ok at cycle 5 ->
//     dreq_out.valid cycles 0-2, finish[0] at cycle 6, rdata unchanged.
//  3) Both valid, flush asserted while in REQ1 before addr_ok -> IDLE, no finish, dreq_out.valid=0 next
//     cycle, slot 0 never issued.
//  4) flush in WAIT1 -> no new request until data_ok; then IDLE, req_finish=2'b00.
//  5) reset asserted in WAIT0 -> all outputs zero immediately; later data_ok ignored.
//  6) FAST_DONE=0, ZERO_WAIT=0, two loads -> WAIT visited each slot, one IDLE bubble; total 6 cycles.

Source files
------------

// File: rtl/dbus_pair_server_if.sv
// rtl/dbus_pair_server_if.sv - dbus request/response types and the pair-server bus interface
//
// Purpose: shared dbus payload types plus the interface that bundles the
// memory-stage side and the downstream side of dbus_pair_server.
// Signals:
//   dreq[1:0]  memory stage requests, [1] older, [0] younger
//   advance    pipeline moves M->W, clears finish bookkeeping
//   flush      cancel slots not yet issued
//   dreqOut    single downstream request
//   drespIn    downstream addrOk / dataOk / data
//   reqFinish  per-slot served flags, sticky until advance
//   rdata      captured raw load word per slot
//   stallM     a valid, unfinished slot remains
package dbus_pkg;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic       valid;
        logic [31:0] addr;
        logic [2:0] size;
        logic [3:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  addrOk;
        logic  dataOk;
        word_t data;
    } dbus_resp_t;
endpackage

interface dbus_pair_if;
    import dbus_pkg::*;

    dbus_req_t  [1:0] dreq;
    logic             advance;
    logic             flush;
    dbus_req_t        dreqOut;
    dbus_resp_t       drespIn;
    logic       [1:0] reqFinish;
    word_t      [1:0] rdata;
    logic             stallM;

    modport slave (
        input  dreq, advance, flush, drespIn,
        output dreqOut, reqFinish, rdata, stallM
    );

    modport master (
        output dreq, advance, flush, drespIn,
        input  dreqOut, reqFinish, rdata, stallM
    );
endinterface

// File: rtl/dbus_pair_server.sv
// rtl/dbus_pair_server.sv - serializes two memory-stage dbus requests onto one downstream dbus
//
// Purpose: issues slot 1 (older) then slot 0 (younger) downstream, one
// transaction outstanding, captures load data and reports per-slot finish.
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset
//   bus   dbus_pair_if.slave (see interface for signal list)
// Parameters:
//   FAST_DONE  1: data_ok with addr_ok completes in the request cycle
//   ZERO_WAIT  1: slot 0 issued right after slot 1 completes
module dbus_pair_server
    import dbus_pkg::*;
#(
    parameter bit FAST_DONE = 1'b1,
    parameter bit ZERO_WAIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    dbus_pair_if.slave bus
);

    typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ0, WAIT0} state_t;

    state_t     state, nextState;
    logic       draining, nextDraining;
    logic [1:0] finish;
    word_t [1:0] rdataQ;

    // With FAST_DONE=0 a response that arrives alongside addr_ok is parked
    // here so the WAIT cycle can complete without a second data_ok.
    logic       heldValid;
    word_t      heldData;

    logic       slot1;
    logic       pending0;
    logic       done;
    logic       kill;
    logic       captureHeld;
    logic       clearHeld;
    logic [1:0] finishSet;
    logic [1:0] rdataWe;
    word_t      respData;
    dbus_req_t  curReq;

    assign slot1    = (state == REQ1) || (state == WAIT1);
    assign curReq   = slot1 ? bus.dreq[1] : bus.dreq[0];
    assign pending0 = bus.dreq[0].valid & ~finish[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            draining  <= 1'b0;
            heldValid <= 1'b0;
            heldData  <= '0;
            finish    <= 2'b00;
            rdataQ    <= '0;
        end else begin
            state    <= nextState;
            draining <= nextDraining;
            if (captureHeld) begin
                heldValid <= 1'b1;
                heldData  <= bus.drespIn.data;
            end else if (clearHeld) begin
                heldValid <= 1'b0;
            end
            if (bus.advance) begin
                finish <= 2'b00;
            end else begin
                finish <= finish | finishSet;
            end
            for (int i = 0; i < 2; i++) begin
                if (rdataWe[i]) begin
                    rdataQ[i] <= respData;
                end
            end
        end
    end

    always_comb begin
        nextState    = state;
        nextDraining = draining;
        done         = 1'b0;
        captureHeld  = 1'b0;
        clearHeld    = 1'b0;
        finishSet    = 2'b00;
        rdataWe      = 2'b00;
        respData     = bus.drespIn.data;
        bus.dreqOut  = '0;
        // A flushed transaction still has to drain downstream, but must not
        // report a finish or write rdata.
        kill         = bus.flush | draining;

        case (state)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.dreq[1].valid && !finish[1]) begin
                        nextState = REQ1;
                    end else if (pending0) begin
                        nextState = REQ0;
                    end
                end
            end
            REQ1, REQ0: begin
                bus.dreqOut       = curReq;
                bus.dreqOut.valid = 1'b1;
                if (bus.drespIn.addrOk) begin
                    // A flushed transaction whose data is already here has
                    // nothing left to drain, so it never enters WAIT.
                    if (bus.drespIn.dataOk && (FAST_DONE || bus.flush)) begin
                        done = 1'b1;
                    end else begin
                        nextState    = slot1 ? WAIT1 : WAIT0;
                        nextDraining = bus.flush;
                        captureHeld  = bus.drespIn.dataOk;
                    end
                end else if (bus.flush) begin
                    nextState = IDLE;
                end
            end
            WAIT1, WAIT0: begin
                if (bus.flush) begin
                    nextDraining = 1'b1;
                end
                if (bus.drespIn.dataOk || heldValid) begin
                    done      = 1'b1;
                    clearHeld = 1'b1;
                    if (heldValid) begin
                        respData = heldData;
                    end
                end
            end
            default: nextState = IDLE;
        endcase

        if (done) begin
            nextDraining = 1'b0;
            if (kill) begin
                nextState = IDLE;
            end else begin
                finishSet = slot1 ? 2'b10 : 2'b01;
                rdataWe   = (curReq.strobe == 4'b0000) ? finishSet : 2'b00;
                nextState = (slot1 && ZERO_WAIT && pending0 && !bus.flush) ? REQ0 : IDLE;
            end
        end
    end

    assign bus.reqFinish = finish;
    assign bus.rdata     = rdataQ;
    assign bus.stallM    = |({bus.dreq[1].valid, bus.dreq[0].valid} & ~finish);

    advanceOnlyIdle: assert property (@(posedge clk) disable iff (rst)
        bus.advance |-> (state == IDLE));

endmodule

// File: tb/tb_dbus_pair_server.sv
// tb/tb_dbus_pair_server.sv - self-checking bench for dbus_pair_server
module tb_dbus_pair_server;
    import dbus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dbus_pair_if busA ();
    dbus_pair_if busB ();

    dbus_pair_server #(.FAST_DONE(1'b1), .ZERO_WAIT(1'b1)) dutA (
        .clk(clk), .rst(rst), .bus(busA.slave));
    dbus_pair_server #(.FAST_DONE(1'b0), .ZERO_WAIT(1'b0)) dutB (
        .clk(clk), .rst(rst), .bus(busB.slave));

    localparam logic [31:0] B_KEY = 32'h5A5A_0000;
    // Downstream for the slow instance: accepts and answers in the same cycle.
    assign busB.drespIn = {busB.dreqOut.valid, busB.dreqOut.valid, busB.dreqOut.addr ^ B_KEY};

    int tests = 0;
    int fails = 0;

    typedef struct { int a; int d; } cfg_t;
    cfg_t        cfgQ[$];
    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    word_t       modelRd[2];

    // Responder for busA: addr_ok after `a` request cycles, data_ok `d`
    // cycles after addr_ok (d=0 means the same cycle).
    bit          haveCfg = 0;
    bit          respOut = 0;
    int          reqCnt = 0;
    int          respWait = 0;
    cfg_t        cur;
    logic [31:0] curData;

    always @(negedge clk) begin
        busA.drespIn = '0;
        if (respOut) begin
            if (respWait == cur.d) begin
                busA.drespIn = {1'b0, 1'b1, curData};
                logData.push_back(curData);
                respOut = 0;
                haveCfg = 0;
            end else begin
                respWait++;
            end
        end else if (busA.dreqOut.valid) begin
            if (!haveCfg) begin
                if (cfgQ.size() > 0) cur = cfgQ.pop_front();
                else cur = '{0, 0};
                haveCfg = 1;
                reqCnt  = 0;
                curData = $urandom;
            end
            if (reqCnt == cur.a) begin
                logAddr.push_back(busA.dreqOut.addr);
                if (cur.d == 0) begin
                    busA.drespIn = {1'b1, 1'b1, curData};
                    logData.push_back(curData);
                    haveCfg = 0;
                end else begin
                    busA.drespIn.addrOk = 1'b1;
                    respOut  = 1;
                    respWait = 1;
                end
            end else begin
                reqCnt++;
            end
        end
    end

    task automatic respReset();
        cfgQ.delete();
        haveCfg = 0;
        respOut = 0;
        reqCnt  = 0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic dbus_req_t mkReq(input bit v, input logic [31:0] addr, input bit store);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = addr;
        r.size   = 3'd2;
        r.strobe = store ? 4'hF : 4'h0;
        r.data   = addr ^ 32'h0000_FFFF;
        return r;
    endfunction

    // One memory-stage occupancy on busA; expected latency supplied by caller.
    task automatic runTrial(input string name, input bit v1, input bit v0, input bit s1, input bit s0,
                            input logic [31:0] ad1, input logic [31:0] ad0,
                            input int a1, input int d1, input int a0, input int d0, input int expCyc);
        int n = 0;
        int idx = 0;
        logAddr.delete();
        logData.delete();
        cfgQ.delete();
        if (v1) cfgQ.push_back('{a1, d1});
        if (v0) cfgQ.push_back('{a0, d0});
        busA.dreq[1] = mkReq(v1, ad1, s1);
        busA.dreq[0] = mkReq(v0, ad0, s0);
        @(negedge clk);
        while (busA.stallM && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({name, " cycles"}, 64'(n), 64'(expCyc));
        check({name, " finish"}, 64'(busA.reqFinish), 64'({v1, v0}));
        check({name, " issued"}, 64'(logAddr.size()), 64'(int'(v1) + int'(v0)));
        if (logAddr.size() == int'(v1) + int'(v0) && logData.size() == logAddr.size()) begin
            if (v1) begin
                check({name, " order1"}, 64'(logAddr[idx]), 64'(ad1));
                if (!s1) modelRd[1] = logData[idx];
                idx++;
            end
            if (v0) begin
                check({name, " order0"}, 64'(logAddr[idx]), 64'(ad0));
                if (!s0) modelRd[0] = logData[idx];
            end
        end
        check({name, " rdata1"}, 64'(busA.rdata[1]), 64'(modelRd[1]));
        check({name, " rdata0"}, 64'(busA.rdata[0]), 64'(modelRd[0]));
        @(posedge clk); #1;
        busA.dreq    = '0;
        busA.advance = 1'b1;
        @(posedge clk); #1;
        busA.advance = 1'b0;
        check({name, " cleared"}, 64'(busA.reqFinish), 64'd0);
    endtask

    typedef struct {
        string       name;
        bit          v1, v0, s1, s0;
        logic [31:0] ad1, ad0;
        int          a1, d1, a0, d0;
        int          expCyc;
    } vec_t;

    initial begin
        vec_t vecs[5];
        bit   seen;
        logic [5:0] pat;
        int   n;

        vecs[0] = '{"two_fast_loads", 1, 1, 0, 0, 32'h8000_0010, 32'h8000_0014, 0, 0, 0, 0, 3};
        vecs[1] = '{"slot0_store",    0, 1, 0, 1, 32'h0,         32'hA000_0000, 0, 0, 2, 3, 7};
        vecs[2] = '{"slot1_only",     1, 0, 0, 0, 32'h8000_0100, 32'h0,         1, 0, 0, 0, 3};
        vecs[3] = '{"store_then_ld",  1, 1, 1, 0, 32'h8000_0200, 32'h8000_0204, 0, 2, 3, 1, 9};
        vecs[4] = '{"none_valid",     0, 0, 0, 0, 32'h0,         32'h0,         0, 0, 0, 0, 0};

        busA.dreq = '0; busA.advance = 1'b0; busA.flush = 1'b0;
        busB.dreq = '0; busB.advance = 1'b0; busB.flush = 1'b0;
        modelRd = '{32'h0, 32'h0};
        repeat (2) @(posedge clk);
        #1;
        check("reset dreqOut", 64'(busA.dreqOut.valid), 64'd0);
        check("reset finish", 64'(busA.reqFinish), 64'd0);
        check("reset rdata", 64'({busA.rdata[1], busA.rdata[0]}), 64'd0);
        check("reset stall", 64'(busA.stallM), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            runTrial(vecs[i].name, vecs[i].v1, vecs[i].v0, vecs[i].s1, vecs[i].s0,
                     vecs[i].ad1, vecs[i].ad0, vecs[i].a1, vecs[i].d1, vecs[i].a0, vecs[i].d0,
                     vecs[i].expCyc);

        // Flush while REQ1 waits for addr_ok: nothing issued, nothing finished.
        logAddr.delete(); logData.delete(); respReset();
        cfgQ.push_back('{5, 0});
        busA.dreq[1] = mkReq(1, 32'h8000_0300, 0);
        busA.dreq[0] = mkReq(1, 32'h8000_0304, 0);
        @(posedge clk); #1;
        check("t3 req1 valid", 64'(busA.dreqOut.valid), 64'd1);
        busA.flush = 1'b1;
        busA.dreq  = '0;
        @(posedge clk); #1;
        busA.flush = 1'b0;
        check("t3 valid dropped", 64'(busA.dreqOut.valid), 64'd0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= busA.dreqOut.valid;
        end
        check("t3 no reissue", 64'(seen), 64'd0);
        check("t3 none accepted", 64'(logAddr.size()), 64'd0);
        check("t3 finish", 64'(busA.reqFinish), 64'd0);
        respReset();
        @(posedge clk); #1;

        // Flush in WAIT1: must drain, then return to IDLE with no finish.
        logAddr.delete(); logData.delete();
        cfgQ.push_back('{0, 4});
        busA.dreq[1] = mkReq(1, 32'h8000_0400, 0);
        busA.dreq[0] = mkReq(1, 32'h8000_0404, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        busA.flush = 1'b1;
        busA.dreq  = '0;
        @(posedge clk); #1;
        busA.flush = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen |= busA.dreqOut.valid;
        end
        check("t4 no new request", 64'(seen), 64'd0);
        check("t4 drained", 64'({logAddr.size(), logData.size()}), {32'd1, 32'd1});
        check("t4 finish", 64'(busA.reqFinish), 64'd0);
        check("t4 stall", 64'(busA.stallM), 64'd0);
        check("t4 rdata", 64'({busA.rdata[1], busA.rdata[0]}), {modelRd[1], modelRd[0]});
        respReset();
        @(posedge clk); #1;

        for (int t = 0; t < 40; t++) begin
            bit v1, v0, s1, s0;
            int a1, d1, a0, d0, cyc;
            v1 = 1'($urandom); v0 = 1'($urandom);
            s1 = 1'($urandom); s0 = 1'($urandom);
            a1 = $urandom_range(3); d1 = $urandom_range(3);
            a0 = $urandom_range(3); d0 = $urandom_range(3);
            cyc = 0;
            if (v1) cyc += a1 + 1 + d1;
            if (v0) cyc += a0 + 1 + d0;
            if (v1 || v0) cyc += 1;
            runTrial($sformatf("rand%0d", t), v1, v0, s1, s0,
                     {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC,
                     a1, d1, a0, d0, cyc);
        end

        // Slow instance: WAIT on every slot and an IDLE bubble between them.
        busB.dreq[1] = mkReq(1, 32'h8000_0010, 0);
        busB.dreq[0] = mkReq(1, 32'h8000_0014, 0);
        n = 0;
        pat = '0;
        @(negedge clk);
        while (busB.stallM && n < 50) begin
            if (n < 6) pat[n] = busB.dreqOut.valid;
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("t6 cycles", 64'(n), 64'd6);
        check("t6 valid pattern", 64'(pat), 64'(6'b010010));
        check("t6 finish", 64'(busB.reqFinish), 64'(2'b11));
        check("t6 rdata1", 64'(busB.rdata[1]), 64'(32'h8000_0010 ^ B_KEY));
        check("t6 rdata0", 64'(busB.rdata[0]), 64'(32'h8000_0014 ^ B_KEY));
        @(posedge clk); #1;
        busB.dreq    = '0;
        busB.advance = 1'b1;
        @(posedge clk); #1;
        busB.advance = 1'b0;
        check("t6 cleared", 64'(busB.reqFinish), 64'd0);

        // Reset mid-WAIT0: outputs clear at once, the late data_ok is ignored.
        runTrial("pre_reset_load", 0, 1, 0, 0, 32'h0, 32'h8000_0500, 0, 0, 0, 0, 2);
        logAddr.delete(); logData.delete(); respReset();
        cfgQ.push_back('{0, 5});
        busA.dreq[0] = mkReq(1, 32'h8000_0600, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        busA.dreq = '0;
        #1;
        check("t5 dreqOut", 64'(busA.dreqOut.valid), 64'd0);
        check("t5 dreqOut addr", 64'(busA.dreqOut.addr), 64'd0);
        check("t5 finish", 64'(busA.reqFinish), 64'd0);
        check("t5 rdata", 64'({busA.rdata[1], busA.rdata[0]}), 64'd0);
        check("t5 stall", 64'(busA.stallM), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t5 late data_ok seen", 64'(logData.size()), 64'd1);
        check("t5 finish after", 64'(busA.reqFinish), 64'd0);
        check("t5 rdata after", 64'({busA.rdata[1], busA.rdata[0]}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1);
    end
endmodule
